// File: rtl/poly_vec_load_scheduler_pkg.sv
// Shared definitions for the polynomial vector load scheduler.
// Holds the FSM state encoding, polynomial slot geometry, and the helper
// that picks the last word index for the selected coefficient packing.
package poly_vec_load_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Every polynomial occupies a 64-word slot, whatever the packing.
  localparam int unsigned POLY_STRIDE = 64;
  localparam int unsigned WORDS_4X    = 64;
  localparam int unsigned WORDS_13B   = 52;

  // The slot stride is a power of two, so the in-slot offset is {poly, word}.
  localparam int unsigned WORD_W = $clog2(POLY_STRIDE);
  localparam int unsigned PIDX_W = 2;

  function automatic logic [WORD_W-1:0] last_word(input logic coeff4x);
    return coeff4x ? WORD_W'(WORDS_4X - 1) : WORD_W'(WORDS_13B - 1);
  endfunction

endpackage

// File: rtl/poly_vec_load_scheduler_if.sv
// Stream-in / BRAM-write bundle for the polynomial vector load scheduler.
//   din, din_valid, din_ready : 64-bit valid/ready input stream
//   bram_we, bram_addr, bram_wdata : registered BRAM write port
// master: host/FIFO side (drives the stream, observes the writes)
// slave : scheduler side
interface poly_vec_load_scheduler_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;

  modport master (
    output din, din_valid,
    input  din_ready, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    input  din, din_valid,
    output din_ready, bram_we, bram_addr, bram_wdata
  );

endinterface

// File: rtl/poly_vec_load_scheduler_word_addr_gen.sv
// Word counter and BRAM address generator for one polynomial slot.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : force the word counter to 0 (has priority over step)
//   step      : advance one word; wraps to 0 after the last word
//   coeff4x   : 1 = 64 words per polynomial, 0 = 52 words
//   base      : BRAM address of word 0 of poly 0
//   poly_idx  : current polynomial
//   last      : current word is the last word of the polynomial
//   addr      : base + poly_idx*POLY_STRIDE + word, mod 2^ADDR_W
module poly_word_addr_gen
  import poly_vec_load_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic              coeff4x,
  input  logic [ADDR_W-1:0] base,
  input  logic [PIDX_W-1:0] poly_idx,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  logic [WORD_W-1:0]        word_q, word_d;
  logic [PIDX_W+WORD_W-1:0] offset;

  assign last   = (word_q == last_word(coeff4x));
  assign offset = {poly_idx, word_q};
  // Sum is truncated to ADDR_W so a high base wraps to the bottom of the BRAM.
  assign addr   = base + ADDR_W'(offset);

  always_comb begin
    word_d = word_q;
    if (clear) begin
      word_d = '0;
    end else if (step) begin
      word_d = last ? '0 : word_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/poly_vec_load_scheduler.sv
// Loads a vector of NPOLY polynomials from a valid/ready stream into the
// polynomial BRAM, one 64-word slot per polynomial.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle request, accepted only when idle
//   abort     : synchronous abort, honoured whenever busy
//   coeff4x   : sampled at start; 1 = 64 words/poly, 0 = 52 words/poly
//   base_addr : sampled at start; BRAM address of word 0 of poly 0
//   bus       : stream input and registered BRAM write port
//   poly_idx  : polynomial currently being loaded
//   busy      : high in every state except idle
//   done      : one-cycle pulse when the whole vector has been written
module poly_vec_load_scheduler
  import poly_vec_load_scheduler_pkg::*;
#(
  parameter int unsigned NPOLY  = 3,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    coeff4x,
  input  logic [ADDR_W-1:0]       base_addr,
  poly_vec_load_scheduler_if.slave bus,
  output logic [PIDX_W-1:0]       poly_idx,
  output logic                    busy,
  output logic                    done
);

  localparam logic [PIDX_W-1:0] LAST_POLY = PIDX_W'(NPOLY - 1);

  state_e              state_q, state_d;
  logic [PIDX_W-1:0]   poly_q, poly_d;
  logic                coeff_q, coeff_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                abort_act;
  logic                beat;
  logic                step;
  logic                wclear;
  logic                wlast;
  logic [ADDR_W-1:0]   waddr;

  assign abort_act = abort && (state_q != StIdle);
  assign beat      = (state_q == StLoad) && bus.din_valid;
  // An aborted beat is neither counted nor written.
  assign step      = beat && !abort_act;
  assign wclear    = (state_q == StIdle) || abort_act;

  poly_word_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (wclear),
    .step     (step),
    .coeff4x  (coeff_q),
    .base     (base_q),
    .poly_idx (poly_q),
    .last     (wlast),
    .addr     (waddr)
  );

  always_comb begin
    state_d = state_q;
    poly_d  = poly_q;
    coeff_d = coeff_q;
    base_d  = base_q;
    done    = 1'b0;
    if (abort_act) begin
      state_d = StIdle;
      poly_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            coeff_d = coeff4x;
            base_d  = base_addr;
            poly_d  = '0;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (beat && wlast) begin
            state_d = StGap;
          end
        end
        StGap: begin
          if (poly_q == LAST_POLY) begin
            state_d = StDone;
          end else begin
            poly_d  = poly_q + 1'b1;
            state_d = StLoad;
          end
        end
        StDone: begin
          done    = 1'b1;
          poly_d  = '0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      poly_q  <= '0;
      coeff_q <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      poly_q  <= poly_d;
      coeff_q <= coeff_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= step;
      if (step) begin
        addr_q  <= waddr;
        wdata_q <= bus.din;
      end
    end
  end

  assign bus.din_ready  = (state_q == StLoad);
  assign bus.bram_we    = we_q;
  assign bus.bram_addr  = addr_q;
  assign bus.bram_wdata = wdata_q;
  assign poly_idx       = poly_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_poly_vec_load_scheduler.sv
// Scoreboard bench for poly_vec_load_scheduler: stimulus pushes the expected
// BRAM write for every accepted beat, a negedge monitor pops and compares.
module tb_poly_vec_load_scheduler;

  localparam int NPOLY  = 3;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 64;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                stamp;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              coeff4x;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        poly_idx;
  logic              busy;
  logic              done;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   cyc_g = 0;
  exp_t exp_q[$];
  exp_t item;

  poly_vec_load_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  poly_vec_load_scheduler #(
    .NPOLY  (NPOLY),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .coeff4x   (coeff4x),
    .base_addr (base_addr),
    .bus       (bus),
    .poly_idx  (poly_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slot p occupies base + 64*p .. base + 64*p + 63, wrapping at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] model_addr(input int base, input int k, input int words);
    int p = k / words;
    int w = k % words;
    return ADDR_W'((base + p * 64 + w) % (1 << ADDR_W));
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (bus.bram_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=0x%0h, required no write", bus.bram_addr,
                   bus.bram_wdata);
        end else begin
          item = exp_q.pop_front();
          chk("bram_addr", 64'(bus.bram_addr), 64'(item.addr));
          chk("bram_wdata", bus.bram_wdata, item.data);
          chk("write_latency", 64'(cyc_g - item.stamp), 64'd1);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 64'(bus.bram_we), 64'd0);
    chk({tag, "_addr"}, 64'(bus.bram_addr), 64'd0);
    chk({tag, "_wdata"}, bus.bram_wdata, 64'd0);
    chk({tag, "_ready"}, 64'(bus.din_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_poly_idx"}, 64'(poly_idx), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.din_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
  endtask

  // vmode: 0 continuous valid, 1 pattern 1,0,0,1, 2 random valid and data.
  task automatic run_vector(input bit c4x, input int base, input int vmode, input bit misuse,
                            input int abort_at, input int rst_at, input bit chk_timing);
    int  words = c4x ? 64 : 52;
    int  tot   = words * NPOLY;
    int  k     = 0;
    int  cyc   = 1;
    int  ph;
    int  done_before = done_cnt;
    bit  gap_next = 1'b0;
    bit  beat;
    exp_t e;
    start = 1'b1;
    coeff4x = c4x;
    base_addr = ADDR_W'(base);
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    while (k < tot) begin
      if (cyc > 2000) begin
        total++;
        bad++;
        $display("FAIL run_timeout: beats=%0d required=%0d", k, tot);
        do_reset();
        return;
      end
      ph = (cyc - 1) % 4;
      case (vmode)
        0:       bus.din_valid = 1'b1;
        1:       bus.din_valid = (ph == 0) || (ph == 3);
        default: bus.din_valid = ($urandom_range(0, 99) < 60);
      endcase
      bus.din = (vmode == 2) ? {$urandom, $urandom} : 64'(k);
      if (misuse) begin
        start = (cyc % 9 == 4);
        base_addr = ADDR_W'($urandom);
        coeff4x = $urandom_range(0, 1) == 1;
      end
      abort = (abort_at >= 0) && (k == abort_at);
      @(negedge clk);
      chk("din_ready", 64'(bus.din_ready), 64'(!gap_next));
      chk("busy_run", 64'(busy), 64'd1);
      chk("done_run", 64'(done), 64'd0);
      chk("poly_idx", 64'(poly_idx), 64'(gap_next ? (k / words) - 1 : k / words));
      beat = bus.din_valid && bus.din_ready;
      if (rst_at >= 0 && k == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        exp_q.delete();
        bus.din_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("busy_after_rst", 64'(busy), 64'd0);
        end
        chk("done_after_rst", 64'(done_cnt), 64'(done_before));
        return;
      end
      if (abort) begin
        @(posedge clk);
        #1 abort = 1'b0;
        bus.din_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ready", 64'(bus.din_ready), 64'd0);
        chk("abort_poly_idx", 64'(poly_idx), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(done_before));
        chk("abort_drained", 64'(exp_q.size()), 64'd0);
        return;
      end
      if (beat) begin
        e.addr = model_addr(base, k, words);
        e.data = bus.din;
        e.stamp = cyc_g;
        exp_q.push_back(e);
        k++;
        gap_next = (k % words == 0);
      end else begin
        gap_next = 1'b0;
      end
      @(posedge clk);
      #1 cyc++;
    end
    start = 1'b0;
    @(negedge clk);
    if (chk_timing) chk("last_write_cycle", 64'(cyc), 64'(tot + NPOLY));
    chk("final_gap_ready", 64'(bus.din_ready), 64'd0);
    chk("final_gap_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_ready", 64'(bus.din_ready), 64'd0);
    chk("done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("done_once", 64'(done_cnt - done_before), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    bus.din_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    coeff4x = 1'b0;
    base_addr = '0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    // abort while idle must be ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);

    run_vector(1'b1, 0, 0, 1'b0, -1, -1, 1'b1);
    run_vector(1'b0, 0, 0, 1'b0, -1, -1, 1'b1);
    run_vector(1'b1, 0, 1, 1'b0, -1, -1, 1'b0);
    run_vector(1'b1, 400, 0, 1'b0, -1, -1, 1'b1);
    run_vector(1'b1, 0, 0, 1'b0, 64 + 10, -1, 1'b0);
    run_vector(1'b1, 0, 0, 1'b0, -1, -1, 1'b1);
    run_vector(1'b1, 37, 2, 1'b1, -1, -1, 1'b0);
    run_vector(1'b1, 5, 0, 1'b0, -1, 2 * 64 + 5, 1'b0);
    run_vector(1'b0, 100, 2, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_vector($urandom_range(0, 1) == 1, int'($urandom_range(0, 511)), 2, 1'b0, -1, -1, 1'b0);
    end
    // start and abort together in idle: start wins
    start = 1'b1;
    abort = 1'b1;
    coeff4x = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_beats_abort", 64'(busy), 64'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/poly_vec_load_scheduler.md
Name: poly_vec_load_scheduler

Overview:
- Sequences loading of a vector of NPOLY polynomials from a 64-bit valid/ready input stream into the polynomial BRAM.
- Generates BRAM write enable and address (base + poly stride + word), and handles per-polynomial word counts, inter-polynomial gaps, abort and a start/done handshake.
- Sits between the host input FIFO and the shared polynomial BRAM write port. The top-level controller invokes it once per vector (e.g. secret or public vector).

Parameters:
- NPOLY, 3, number of polynomials per vector (1..4).
- ADDR_W, 9, BRAM address width.
- DATA_W, 64, stream and BRAM word width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous abort; honoured in any non-IDLE state
- coeff4x  in  1  sampled at start; 1 = 64 words/poly (4x uint16), 0 = 52 words/poly (13-bit packed)
- base_addr  in  ADDR_W  sampled at start; BRAM address of word 0 of poly 0
- din  in  DATA_W  stream data
- din_valid  in  1  stream valid
- din_ready  out  1  stream ready
- bram_we  out  1  BRAM write enable (registered)
- bram_addr  out  ADDR_W  BRAM write address (registered)
- bram_wdata  out  DATA_W  BRAM write data (registered)
- poly_idx  out  2  index of the polynomial being loaded
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the vector is complete

Behaviour:
- Reset: asynchronous. State IDLE; counters, base and mode registers cleared; all outputs 0.
- States: IDLE, LOAD, GAP, DONE.
- IDLE:
  - start=1 latches coeff4x and base_addr, clears poly_idx and the word counter, and goes to LOAD.
  - start in any other state is ignored.
- LOAD:
  - din_ready=1 (combinational from state; does not depend on din_valid).
  - A beat is din_valid&&din_ready. On each beat, next cycle: bram_we=1, bram_wdata=din, bram_addr=base+{poly_idx,word[5:0]}, truncated mod 2^ADDR_W. Latency is 1 cycle.
  - The word counter increments on each beat only.
  - Last word is 63 (coeff4x=1) or 51 (coeff4x=0). The poly stride is always 64, so in 52-word mode words 52..63 of each slot are left unwritten.
  - On the last-word beat: word counter resets to 0 and state goes to GAP.
- GAP (1 cycle):
  - din_ready=0; the last word's write is issued this cycle.
  - If poly_idx==NPOLY-1, go to DONE; otherwise increment poly_idx and go to LOAD.
- DONE (1 cycle): done=1, din_ready=0, then IDLE. Every write has already been issued before done.
- bram_we is 0 in every cycle that does not follow a beat.
- abort=1 in LOAD, GAP or DONE:
  - Next state is IDLE; a write still pending from a beat in the abort cycle is suppressed (bram_we=0 next cycle).
  - done is not pulsed; counters are cleared.
  - abort takes priority over the beat/last-word logic.
  - abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- Throughput with continuous valid, start at cycle 0:
  - LOAD begins cycle 1; each poly takes words+1 cycles (the +1 is the gap).
  - coeff4x=1, NPOLY=3: last write at cycle 195, done at 196.
  - coeff4x=0: last write at cycle 159, done at 160.
- Reset mid-operation: immediate return to IDLE; no spurious write or done after release.

Decomposition:
- Shared package: state encoding, POLY_STRIDE=64, WORDS_4X=64, WORDS_13B=52.
- One natural sub-module, poly_word_addr_gen: word counter, last-word detect and address adder, driven by step/clear inputs. The FSM and handshake stay in the top.

Test Plan:
- coeff4x=1, base=0, din_valid held 1, din=beat index:
  - 192 writes to addresses 0..63, 64..127, 128..191 with wdata equal to the beat index.
  - din_ready low at cycles 65, 130 and 195; done only at cycle 196.
- coeff4x=0, base=0:
  - writes to 0..51, 64..115, 128..179; no writes to 52..63 etc.
  - done at cycle 160; busy high cycles 1..160.
- Backpressure, din_valid pattern 1,0,0,1 repeating:
  - bram_we only in cycles after valid beats; addresses contiguous.
  - exactly 192 writes (4x mode), done exactly once.
- Wrap: ADDR_W=9, base=400, coeff4x=1:
  - addresses 400..511 then 0..79.
- Abort:
  - abort asserted on the beat of poly 1, word 10: no write for that beat, no done, state IDLE next cycle, busy=0.
  - a following start reloads from poly 0, word 0.
- Misuse and reset:
  - start pulses during LOAD are ignored, with no restart and no change to base.
  - async rst asserted mid-poly-2 drives all outputs to 0 immediately.
  - a fresh start after release completes normally.
